// File: rtl/alu_arbiter.sv
// Shares the single ALU between the PC unit (req0) and the execute stage (req1).
// Default arbitration is round-robin; define ALU_ARB_FIXED_PRIO_EN to always favour req1 on a tie.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_action,
  input  logic [2:0]       req0_btype,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_action,
  input  logic [2:0]       req1_btype,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_action,
  output logic [2:0]       alu_btype,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_bcond,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_bcond,
  output logic             resp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] ACTION_PASS_A = 4'd9;
  localparam logic [3:0] ACTION_MAX    = 4'd9;
  localparam logic [2:0] BTYPE_MAX     = 3'd4;

  state_t           state_q, state_d;
  logic [3:0]       action_q, action_d;
  logic [2:0]       btype_q, btype_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             grant_id_q, grant_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_bcond_q, resp_bcond_d;
  logic             resp_err_q, resp_err_d;

  logic sel_id;
  logic xfer;
  logic illegal;

  // Reset wins over a pending request, so no handshake completes while it is high.
  assign xfer       = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready = xfer && !sel_id;
  assign req1_ready = xfer && sel_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign sel_id = req1_valid;
`else
  logic last_id_q, last_id_d;

  assign sel_id = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;

  always_comb begin
    last_id_d = last_id_q;
    if (xfer) last_id_d = sel_id;
  end

  // Starts at 1 so that req0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) last_id_q <= 1'b1;
    else       last_id_q <= last_id_d;
  end
`endif

  assign illegal = (action_q > ACTION_MAX) || (btype_q > BTYPE_MAX);

  always_comb begin
    state_d       = state_q;
    action_d      = action_q;
    btype_d       = btype_q;
    a_d           = a_q;
    b_d           = b_q;
    grant_id_d    = grant_id_q;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_bcond_d  = resp_bcond_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = EXEC;
          grant_id_d = sel_id;
          action_d   = sel_id ? req1_action : req0_action;
          btype_d    = sel_id ? req1_btype  : req0_btype;
          a_d        = sel_id ? req1_a      : req0_a;
          b_d        = sel_id ? req1_b      : req0_b;
        end
      end
      EXEC: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_id_d     = grant_id_q;
        resp_err_d    = illegal;
        resp_result_d = illegal ? '0 : alu_result;
        resp_bcond_d  = illegal ? 1'b0 : alu_bcond;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      action_q      <= ACTION_PASS_A;
      btype_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      grant_id_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_bcond_q  <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      action_q      <= action_d;
      btype_q       <= btype_d;
      a_q           <= a_d;
      b_q           <= b_d;
      grant_id_q    <= grant_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_bcond_q  <= resp_bcond_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign alu_action  = action_q;
  assign alu_btype   = btype_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_bcond  = resp_bcond_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle-level reference model predicts grants and responses,
// a separate monitor pops expectations whenever resp_valid is seen.
module tb_alu_arbiter;

  localparam int W = 16;

  typedef struct packed {
    logic [3:0]   action;
    logic [2:0]   btype;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic         bcond;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         vld[2];
  logic [3:0]   act[2];
  logic [2:0]   bty[2];
  logic [W-1:0] av[2];
  logic [W-1:0] bv[2];
  logic         acc[2];

  logic         req0_ready, req1_ready;
  logic [3:0]   alu_action;
  logic [2:0]   alu_btype;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_bcond;
  logic         resp_valid, resp_id, resp_bcond, resp_err, busy;
  logic [W-1:0] resp_result;

  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;
  int   cycle = 0;
  int   m_phase = 0;
  logic m_last = 1'b1;
  exp_t sb[$];
  op_t  opq0[$];
  op_t  opq1[$];
  logic resp_ids[$];
  int   resp_cycles[$];
  int   resp_count = 0;
  int   busy_cycles = 0;
  logic [W-1:0] last_result;
  logic last_id_seen, last_bcond, last_err;

  // Behavioural ALU: illegal codes return junk so the arbiter's forcing to zero is visible.
  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ~x;
      4'd6: return x << 1;
      4'd7: return x >> 1;
      4'd8: return y;
      4'd9: return x;
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic bcond_ref(input logic [2:0] bt, input logic [W-1:0] x, input logic [W-1:0] y);
    case (bt)
      3'd0: return 1'b0;
      3'd1: return x != y;
      3'd2: return x == y;
      3'd3: return $signed(x) > 0;
      3'd4: return $signed(x) < 0;
      default: return 1'b1;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_action, alu_a, alu_b);
  assign alu_bcond  = bcond_ref(alu_btype, alu_a, alu_b);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst),
    .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_action(act[0]), .req0_btype(bty[0]),
    .req0_a(av[0]), .req0_b(bv[0]),
    .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_action(act[1]), .req1_btype(bty[1]),
    .req1_a(av[1]), .req1_b(bv[1]),
    .alu_action(alu_action), .alu_btype(alu_btype), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_bcond(alu_bcond),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_bcond(resp_bcond), .resp_err(resp_err), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [3:0] op, input logic [2:0] bt,
                               input logic [W-1:0] x, input logic [W-1:0] y);
    op_t o;
    o.action = op; o.btype = bt; o.a = x; o.b = y;
    if (id) opq1.push_back(o);
    else    opq0.push_back(o);
  endtask

  // Requesters hold valid until the handshake seen on the previous falling edge, then load the next op.
  task automatic driveCycle();
    op_t o;
    @(posedge clk); #1;
    if (vld[0] && acc[0]) vld[0] = 1'b0;
    if (vld[1] && acc[1]) vld[1] = 1'b0;
    if (!vld[0] && opq0.size() > 0) begin
      o = opq0.pop_front();
      vld[0] = 1'b1; act[0] = o.action; bty[0] = o.btype; av[0] = o.a; bv[0] = o.b;
    end
    if (!vld[1] && opq1.size() > 0) begin
      o = opq1.pop_front();
      vld[1] = 1'b1; act[1] = o.action; bty[1] = o.btype; av[1] = o.a; bv[1] = o.b;
    end
  endtask

  function automatic bit idleNow();
    return opq0.size() == 0 && opq1.size() == 0 && !vld[0] && !vld[1] && m_phase == 0 && sb.size() == 0;
  endfunction

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!idleNow() && n < budget) begin
      driveCycle();
      n++;
    end
    checkOutput("drain_done", idleNow(), 1);
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    repeat (n) driveCycle();
    rst = 1'b0;
  endtask

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    acc[0] = vld[0] && req0_ready;
    acc[1] = vld[1] && req1_ready;
    if (busy) busy_cycles++;
  end

  // Reference model: phase 0 idle, 1 operating on the ALU, 2 presenting the response.
  always @(negedge clk) begin
    if (check_en) begin
      logic g;
      logic take;
      exp_t e;
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = vld[1];
`else
      g = (vld[0] && vld[1]) ? ~m_last : vld[1];
`endif
      take = (m_phase == 0) && !rst && (vld[0] || vld[1]);
      checkOutput("busy", busy, m_phase != 0);
      checkOutput("resp_valid", resp_valid, m_phase == 2);
      checkOutput("req0_ready", req0_ready, take && !g);
      checkOutput("req1_ready", req1_ready, take && g);
      if (rst) begin
        m_phase = 0;
        m_last  = 1'b1;
        sb.delete();
      end else if (take) begin
        e.id     = g;
        e.err    = (act[g] > 4'd9) || (bty[g] > 3'd4);
        e.result = e.err ? '0 : alu_ref(act[g], av[g], bv[g]);
        e.bcond  = e.err ? 1'b0 : bcond_ref(bty[g], av[g], bv[g]);
        sb.push_back(e);
        m_last  = g;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && resp_valid) begin
      exp_t e;
      checkOutput("resp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("resp_id", resp_id, e.id);
        checkOutput("resp_result", resp_result, e.result);
        checkOutput("resp_bcond", resp_bcond, e.bcond);
        checkOutput("resp_err", resp_err, e.err);
      end
      resp_ids.push_back(resp_id);
      resp_cycles.push_back(cycle);
      resp_count++;
      last_result  = resp_result;
      last_id_seen = resp_id;
      last_bcond   = resp_bcond;
      last_err     = resp_err;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic exp_ids[4];
    int n0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; act[i] = '0; bty[i] = '0; av[i] = '0; bv[i] = '0; acc[i] = 1'b0;
    end

    // Reset state, with req0 already valid: reset must win over the request.
    rst = 1'b1;
    driveCycle();
    check_en = 1'b1;
    vld[0] = 1'b1; act[0] = 4'd0; bty[0] = 3'd0; av[0] = 16'h0003; bv[0] = 16'h0004;
    driveCycle();
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_id", resp_id, 0);
    checkOutput("rst_resp_result", resp_result, 0);
    checkOutput("rst_resp_bcond", resp_bcond, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_action", alu_action, 9);
    checkOutput("rst_alu_btype", alu_btype, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_req0_ready", req0_ready, 0);
    rst = 1'b0;

    $display("[TB] req0 add 3+4");
    waitIdle(20);
    checkOutput("t1_result", last_result, 16'h0007);
    checkOutput("t1_id", last_id_seen, 0);
    checkOutput("t1_err", last_err, 0);

    $display("[TB] req1 sub with beq");
    busy_cycles = 0;
    applyStimulus(1'b1, 4'd1, 3'd2, 16'h0010, 16'h0010);
    waitIdle(20);
    checkOutput("t2_result", last_result, 16'h0000);
    checkOutput("t2_bcond", last_bcond, 1);
    checkOutput("t2_id", last_id_seen, 1);
    checkOutput("t2_busy_cycles", busy_cycles, 2);

    $display("[TB] back-to-back contention");
    doReset(1);
    resp_ids.delete();
    resp_cycles.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'($urandom_range(0, 9)), 3'($urandom_range(0, 4)), 16'($urandom), 16'($urandom));
      applyStimulus(1'b1, 4'($urandom_range(0, 9)), 3'($urandom_range(0, 4)), 16'($urandom), 16'($urandom));
    end
    waitIdle(100);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    checkOutput("b2b_count", resp_ids.size(), 8);
    for (int k = 0; k < 4; k++) begin
      if (k < resp_ids.size()) checkOutput("b2b_grant_order", resp_ids[k], exp_ids[k]);
    end
    for (int k = 0; k + 1 < resp_cycles.size(); k++) begin
      checkOutput("b2b_spacing", resp_cycles[k+1] - resp_cycles[k], 3);
    end

    $display("[TB] illegal codes then legal op");
    applyStimulus(1'b0, 4'd12, 3'd0, 16'h0005, 16'h0006);
    waitIdle(20);
    checkOutput("err_flag", last_err, 1);
    checkOutput("err_result", last_result, 0);
    checkOutput("err_bcond", last_bcond, 0);
    applyStimulus(1'b0, 4'd3, 3'd5, 16'h0005, 16'h0005);
    waitIdle(20);
    checkOutput("err_btype_flag", last_err, 1);
    checkOutput("err_btype_bcond", last_bcond, 0);
    applyStimulus(1'b0, 4'd9, 3'd0, 16'h1234, 16'h0000);
    waitIdle(20);
    checkOutput("err_cleared", last_err, 0);
    checkOutput("err_cleared_result", last_result, 16'h1234);

    $display("[TB] reset during operation");
    n0 = resp_count;
    applyStimulus(1'b0, 4'd0, 3'd0, 16'h0001, 16'h0001);
    driveCycle();
    driveCycle();
    rst = 1'b1;
    driveCycle();
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_resp_valid", resp_valid, 0);
    driveCycle();
    driveCycle();
    checkOutput("abort_no_resp", resp_count, n0);
    applyStimulus(1'b0, 4'd0, 3'd0, 16'h0020, 16'h0002);
    waitIdle(20);
    checkOutput("abort_recover_count", resp_count, n0 + 1);
    checkOutput("abort_recover_result", last_result, 16'h0022);

    $display("[TB] req0 valid pulse while busy");
    n0 = resp_count;
    applyStimulus(1'b1, 4'd4, 3'd1, 16'h00F0, 16'h0F00);
    driveCycle();
    driveCycle();
    vld[0] = 1'b1; act[0] = 4'd0; bty[0] = 3'd0; av[0] = 16'h0001; bv[0] = 16'h0001;
    driveCycle();
    checkOutput("pulse_ready0", req0_ready, 0);
    vld[0] = 1'b0;
    driveCycle();
    checkOutput("pulse_idle_busy", busy, 0);
    waitIdle(20);
    checkOutput("pulse_count", resp_count, n0 + 1);
    checkOutput("pulse_id", last_id_seen, 1);
    checkOutput("pulse_result", last_result, 16'h0FF0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 3'($urandom_range(0, 5)),
                    16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 4)) driveCycle();
    end
    waitIdle(2000);

    checkOutput("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
